p_result_uart_tx: RTL and testbench

//  Transmit end of the servo controller's serial link. Accepts a signed P-stage result word,

---
 rtl/servo_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/p_result_uart_tx.sv | 151 +++++++++++++++
 tb/tb_p_result_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// ============================================================================
// Module     : servo_pkg
// Description: Shared UART/servo-link types and constants (TX state encoding,
//              line idle level, default baud divider shared with the RX side).
// Revision   : 1.0
// ============================================================================
`default_nettype none

package servo_pkg;

  localparam int CLK_DIV_DEFAULT = 434;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module     : uart_baud_tick
// Description: Baud-rate divider; counts 0..CLK_DIV-1 and flags the last count.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic Clk_G,
  input  logic Rst_G_n,
  input  logic clr,
  output logic tick
);

  localparam int            c_cw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge Clk_G or negedge Rst_G_n) begin
    if (!Rst_G_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign tick = !clr && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/p_result_uart_tx.sv
// ============================================================================
// Module     : p_result_uart_tx
// Description: Sends a sign-extended P-stage result word MSB byte first as
//              UART frames (8N1, or 8E1 when P_TX_PARITY_EN is defined).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module p_result_uart_tx
  import servo_pkg::*;
#(
  parameter int cant_bits = 13,
  parameter int CLK_DIV   = CLK_DIV_DEFAULT
) (
  input  logic                   Clk_G,
  input  logic                   Rst_G_n,
  input  logic [2*cant_bits-1:0] Dato,
  input  logic                   Tx_Start,
  output logic                   Tx,
  output logic                   Tx_Busy,
  output logic                   Tx_Done
);

  localparam int NBYTES = (2*cant_bits + 7) / 8;
  localparam int c_dw   = 2*cant_bits;
  localparam int c_xw   = NBYTES * 8;
  localparam int c_biw  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [c_biw-1:0] c_last_byte = c_biw'(NBYTES - 1);

  tx_state_e          r_state;
  logic [c_xw-1:0]    r_shift;
  logic [6:0]         r_byte;
  logic [c_biw-1:0]   r_byte_idx;
  logic [2:0]         r_bit_idx;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;
`ifdef P_TX_PARITY_EN
  logic               r_par;
`endif

  logic signed [c_dw-1:0] w_dato_s;
  logic [c_xw-1:0]        w_ext;
  logic                   w_tick;
  logic                   w_baud_clr;

  assign w_dato_s   = Dato;
  assign w_ext      = c_xw'(w_dato_s);
  assign w_baud_clr = (r_state == ST_IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .Clk_G   (Clk_G),
    .Rst_G_n (Rst_G_n),
    .clr     (w_baud_clr),
    .tick    (w_tick)
  );

  // The word register shifts up a byte per START; r_byte holds the bits still to send.
  always_ff @(posedge Clk_G or negedge Rst_G_n) begin
    if (!Rst_G_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_byte     <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_tx       <= UART_IDLE_LVL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef P_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Tx_Start) begin
            r_shift    <= w_ext;
            r_byte_idx <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_byte    <= r_shift[c_xw-1 -: 7];
            r_tx      <= r_shift[c_xw-8];
            r_shift   <= r_shift << 8;
            r_bit_idx <= '0;
`ifdef P_TX_PARITY_EN
            r_par     <= ^r_shift[c_xw-1 -: 8];
`endif
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
`ifdef P_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= ST_PARITY;
`else
              r_tx    <= UART_IDLE_LVL;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_byte[0];
              r_byte    <= {1'b0, r_byte[6:1]};
            end
          end
        end
`ifdef P_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= UART_IDLE_LVL;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_byte_idx == c_last_byte) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + c_biw'(1);
              r_tx       <= 1'b0;
              r_state    <= ST_START;
            end
          end
        end
        default: begin
          r_tx    <= UART_IDLE_LVL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Tx      = r_tx;
  assign Tx_Busy = r_busy;
  assign Tx_Done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_p_result_uart_tx.sv
// ============================================================================
// Module     : tb_p_result_uart_tx
// Description: Self-checking bench for p_result_uart_tx (CLK_DIV=4, cant_bits=13).
// Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_p_result_uart_tx;

  localparam int DIV = 4;
  localparam int CB  = 13;
  localparam int DW  = 2*CB;
`ifdef P_TX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int EXP_LEN = 176;
`else
  localparam int NBITS   = 10;
  localparam int EXP_LEN = 160;
`endif
  localparam int STOP_OFF = DIV*(NBITS-1) + DIV/2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dato = '0;
  logic          tx, busy, done;

  always #5 clk = ~clk;

  p_result_uart_tx #(.cant_bits(CB), .CLK_DIV(DIV)) dut (
    .Clk_G    (clk),
    .Rst_G_n  (rst_n),
    .Dato     (dato),
    .Tx_Start (start),
    .Tx       (tx),
    .Tx_Busy  (busy),
    .Tx_Done  (done)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference: word value as 32-bit two's complement, bytes MSB first, bits LSB first.
  function automatic logic [31:0] ext32(input logic [DW-1:0] d);
    int v;
    v = $signed(d);
    return v;
  endfunction

  task automatic build_frame(input logic [DW-1:0] d, output bit q[$], output logic [7:0] bs[$]);
    logic [31:0] w;
    q.delete();
    bs.delete();
    w = ext32(d);
    for (int b = 3; b >= 0; b--) begin
      logic [7:0] by;
      by = 8'((w >> (8*b)) & 32'hFF);
      bs.push_back(by);
      for (int c = 0; c < DIV; c++) q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < DIV; c++) q.push_back(by[i]);
`ifdef P_TX_PARITY_EN
      for (int c = 0; c < DIV; c++) q.push_back(bit'($countones(by) % 2));
`endif
      for (int c = 0; c < DIV; c++) q.push_back(1'b1);
    end
  endtask

  bit          mq[$];
  bit          fq[$];
  logic [7:0]  fb[$];
  logic [7:0]  m_bytes[$];
  logic        m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    end else if (mq.size() > 0) begin
      m_tx = mq.pop_front(); m_busy = 1'b1; m_done = 1'b0;
    end else if (m_busy) begin
      m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b1;
    end else begin
      m_tx = 1'b1; m_done = 1'b0;
      if (start) begin
        build_frame(dato, fq, fb);
        mq = fq;
        foreach (fb[i]) m_bytes.push_back(fb[i]);
        m_tx = mq.pop_front();
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      n_total++;
      if (tx === m_tx && busy === m_busy && done === m_done) n_pass++;
      else $display("FAIL cycle_cmp t=%0t actual tx/busy/done=%b%b%b required=%b%b%b",
                    $time, tx, busy, done, m_tx, m_busy, m_done);
    end
  end

  // Independent line decoder, samples mid-bit.
  int         rx_cnt = 0;
  bit         rx_act = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_bytes[$];
  bit         rx_par[$];
  int         rx_frame_err = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt >= DIV + DIV/2 && rx_cnt < 9*DIV && (rx_cnt % DIV) == DIV/2)
        rx_sh[rx_cnt/DIV - 1] = tx;
`ifdef P_TX_PARITY_EN
      if (rx_cnt == 9*DIV + DIV/2) rx_par.push_back(tx);
`endif
      if (rx_cnt == STOP_OFF) begin
        if (tx !== 1'b1) rx_frame_err++;
        rx_bytes.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic clear_stats();
    rx_bytes.delete(); rx_par.delete(); m_bytes.delete();
    done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk); dato = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      n_total++;
      $display("FAIL %s_timeout actual=no Tx_Done required=Tx_Done", nm);
    end
    @(negedge clk);
  endtask

  task automatic chk_bytes(input string nm, input int base,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_b%0d", nm, i),
          (base + i < rx_bytes.size()) ? 32'(rx_bytes[base+i]) : 32'hBAD, 32'(e[i]));
  endtask

  initial begin
    bit          q[$];
    logic [7:0]  bs[$];
    int          n;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);

    chk("model_ext_pos", ext32(26'sd1234), 32'h000004D2);
    chk("model_ext_neg", ext32(-26'sd18), 32'hFFFFFFEE);
    build_frame(26'sd1234, q, bs);
    chk("model_len", q.size(), EXP_LEN);
    chk("model_b3", bs[3], 8'hD2);

    rst_n = 1'b1; chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, positive
    clear_stats();
    send(26'sd1234);
    chk("t1_latency_tx", tx, 0);
    wait_done("t1");
    chk("t1_nbytes", rx_bytes.size(), 4);
    chk_bytes("t1", 0, 8'h00, 8'h00, 8'h04, 8'hD2);
    chk("t1_busy_len", busy_cnt, EXP_LEN);
    chk("t1_done_cnt", done_cnt, 1);
`ifdef P_TX_PARITY_EN
    chk("t1_par", {28'd0, (rx_par.size() > 0) ? rx_par[0] : 1'bx, (rx_par.size() > 1) ? rx_par[1] : 1'bx,
                   (rx_par.size() > 2) ? rx_par[2] : 1'bx, (rx_par.size() > 3) ? rx_par[3] : 1'bx}, 32'h2);
`endif

    // Negative word, sign extension
    clear_stats();
    send(-26'sd18);
    wait_done("t2");
    chk_bytes("t2", 0, 8'hFF, 8'hFF, 8'hFF, 8'hEE);

    // Start pulse mid-frame is ignored
    clear_stats();
    send(26'h1ABCDEF);
    repeat (70) @(negedge clk);
    dato = 26'sd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("t3");
    repeat (20) @(negedge clk);
    chk("t3_nbytes", rx_bytes.size(), 4);
    chk_bytes("t3", 0, 8'h01, 8'hAB, 8'hCD, 8'hEF);
    chk("t3_done_cnt", done_cnt, 1);

    // Start held high: back-to-back words
    clear_stats();
    @(negedge clk); dato = 26'sd5; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    dato = 26'sd1234;
    @(negedge clk);
    chk("t4_gap_tx", tx, 0);
    chk("t4_gap_busy", busy, 1);
    start = 1'b0;
    wait_done("t4");
    chk("t4_nbytes", rx_bytes.size(), 8);
    chk_bytes("t4w0", 0, 8'h00, 8'h00, 8'h00, 8'h05);
    chk_bytes("t4w1", 4, 8'h00, 8'h00, 8'h04, 8'hD2);
    chk("t4_done_cnt", done_cnt, 2);

    // Reset during byte 2
    clear_stats();
    send(26'h0123456);
    repeat (88) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_partial", rx_bytes.size(), 2);
    @(negedge clk); rst_n = 1'b1;
    clear_stats();
    send(-26'sd1);
    wait_done("t5b");
    chk_bytes("t5b", 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Randomized words with junk starts and Dato changes while busy
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      int hold;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      dato = DW'($urandom);
      start = 1'b1;
      hold = $urandom_range(1, 3);
      repeat (hold) @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
        start = ($urandom_range(0, 7) == 0);
        if (start) dato = DW'($urandom);
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      if (n >= 3000) begin
        n_total++;
        $display("FAIL rnd_timeout actual=no Tx_Done required=Tx_Done");
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("rnd_nbytes", rx_bytes.size(), m_bytes.size());
    for (int i = 0; i < m_bytes.size(); i++)
      chk($sformatf("rnd_b%0d", i), (i < rx_bytes.size()) ? 32'(rx_bytes[i]) : 32'hBAD, 32'(m_bytes[i]));
    chk("frame_err", rx_frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
